// File: rtl/zed_pkg.sv
// Shared blitter definitions for the source-Z generator.
// State encoding, phrase geometry and Z fixed-point layout.
package zed_pkg;

   localparam int NPIX  = 4;
   localparam int ZFRAC = 16;

   typedef enum logic [1:0] {
      IDLE,
      RELOAD,
      RUN
   } zed_state_t;

endpackage

// File: rtl/zed_lane.sv
// One 16.16 Z accumulator for pixel lane IDX of a phrase.
// Reloads to base + IDX*inc, or steps by the phrase increment.
module zed_lane #(
   parameter int IDX = 0,
   parameter int ZW  = 32
) (
   input  logic          clk,
   input  logic          resetl,
   input  logic          reload,
   input  logic          step,
   input  logic [ZW-1:0] base,
   input  logic [ZW-1:0] inc,
   input  logic [ZW-1:0] inc4,
   output logic [15:0]   zi
);
   import zed_pkg::*;

   localparam logic [1:0] I = IDX[1:0];

   logic [ZW-1:0] acc;
   logic [ZW-1:0] off;
   logic [ZW-1:0] inc2;

   assign inc2 = {inc[ZW-2:0], 1'b0};
   // IDX*inc built from the two index bits, no multiplier
   assign off  = (I[0] ? inc  : '0)
               + (I[1] ? inc2 : '0);

   always_ff @(posedge clk) begin
      if (!resetl)
         acc <= '0;
      else if (reload)
         acc <= base + off;
      else if (step)
         acc <= acc + inc4;
   end

   assign zi = acc[ZFRAC +: 16];

endmodule

// File: rtl/zed_gen.sv
// Source-Z generator: steps four lane Z values per phrase and line,
// presenting integer Z parts as packed srcz words.
module zed_gen #(
   parameter int NPIX = 4,
   parameter int ZW   = 32
) (
   input  logic          clk,
   input  logic          resetl,
   input  logic          load,
   input  logic [ZW-1:0] zstart,
   input  logic [ZW-1:0] zinc,
   input  logic [ZW-1:0] zstep,
   input  logic          nextline,
   input  logic          abort,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [31:0]   srczplo,
   output logic [31:0]   srczphi,
   output logic          busy
);
   import zed_pkg::*;

   zed_state_t state_q, state_d;

   logic [ZW-1:0] line_z;
   logic [ZW-1:0] zinc_r;
   logic [ZW-1:0] zstep_r;
   logic [ZW-1:0] inc4;
   logic [15:0]   zi [NPIX];
   logic          lane_reload;
   logic          lane_step;
   logic          xfer;

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign xfer      = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      lane_reload = 1'b0;
      lane_step   = 1'b0;
      if (load)
         state_d = RELOAD;
      else if (abort)
         state_d = IDLE;
      else begin
         case (state_q)
            RELOAD: begin
               state_d     = RUN;
               lane_reload = 1'b1;
            end
            RUN: begin
               if (nextline)
                  state_d = RELOAD;
               else if (xfer)
                  lane_step = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetl) begin
         state_q <= IDLE;
         line_z  <= '0;
         zinc_r  <= '0;
         zstep_r <= '0;
         inc4    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            line_z  <= zstart;
            zinc_r  <= zinc;
            zstep_r <= zstep;
            inc4    <= {zinc[ZW-3:0], 2'b00};
         end else if (!abort && state_q == RUN
                      && nextline)
            line_z <= line_z + zstep_r;
      end
   end

   for (genvar k = 0; k < NPIX; k++) begin : g_lane
      zed_lane #(
         .IDX (k),
         .ZW  (ZW)
      ) u_lane (
         .clk    (clk),
         .resetl (resetl),
         .reload (lane_reload),
         .step   (lane_step),
         .base   (line_z),
         .inc    (zinc_r),
         .inc4   (inc4),
         .zi     (zi[k])
      );
   end

   assign srczplo = {zi[1], zi[0]};
   assign srczphi = {zi[3], zi[2]};

endmodule

// File: tb/tb_zed_gen.sv
// Directed bench for zed_gen with an expected-phrase scoreboard.
module tb_zed_gen;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } phrase_t;

   logic        clk = 1'b0;
   logic        resetl;
   logic        load;
   logic [31:0] zstart;
   logic [31:0] zinc;
   logic [31:0] zstep;
   logic        nextline;
   logic        abort;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] srczplo;
   logic [31:0] srczphi;
   logic        busy;

   int tests = 0;
   int fails = 0;
   phrase_t sb[$];

   zed_gen dut (
      .clk       (clk),
      .resetl    (resetl),
      .load      (load),
      .zstart    (zstart),
      .zinc      (zinc),
      .zstep     (zstep),
      .nextline  (nextline),
      .abort     (abort),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .srczplo   (srczplo),
      .srczphi   (srczphi),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic expect_ph(input logic [31:0] lo,
                            input logic [31:0] hi);
      sb.push_back('{lo: lo, hi: hi});
   endtask

   // wait (bounded) for a valid phrase, then score it
   task automatic drain(input string tag);
      phrase_t e;
      int n;
      n = 0;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      if (!out_valid) begin
         chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_lo"}, srczplo, e.lo);
         chk({tag, "_hi"}, srczphi, e.hi);
      end
   endtask

   task automatic do_load(input logic [31:0] s,
                          input logic [31:0] i,
                          input logic [31:0] l);
      zstart = s;
      zinc   = i;
      zstep  = l;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   initial begin
      resetl    = 1'b0;
      load      = 1'b0;
      zstart    = '0;
      zinc      = '0;
      zstep     = '0;
      nextline  = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      resetl = 1'b1;
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lo", srczplo, 32'h0);
      chk("rst_hi", srczphi, 32'h0);

      nextline = 1'b1;
      step();
      nextline = 1'b0;
      chk("idle_nextline_busy", 32'(busy), 32'd0);

      do_load(32'h0010_0000, 32'h0000_8000, 32'h0);
      chk("reload_valid", 32'(out_valid), 32'd0);
      chk("reload_busy", 32'(busy), 32'd1);
      step();
      chk("lat2_valid", 32'(out_valid), 32'd1);
      expect_ph(32'h0010_0010, 32'h0011_0011);
      drain("first");

      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      expect_ph(32'h0012_0012, 32'h0013_0013);
      drain("xfer1");
      for (int c = 0; c < 5; c++) begin
         step();
         expect_ph(32'h0012_0012, 32'h0013_0013);
         drain("stall");
      end

      do_load(32'h0010_0000, 32'h0000_8000,
              32'h0100_0000);
      step();
      out_ready = 1'b1;
      step();
      expect_ph(32'h0012_0012, 32'h0013_0013);
      drain("tp1");
      step();
      out_ready = 1'b0;
      expect_ph(32'h0014_0014, 32'h0015_0015);
      drain("tp2");
      nextline = 1'b1;
      step();
      nextline = 1'b0;
      chk("nl_valid", 32'(out_valid), 32'd0);
      chk("nl_busy", 32'(busy), 32'd1);
      step();
      chk("nl_valid2", 32'(out_valid), 32'd1);
      expect_ph(32'h0110_0110, 32'h0111_0111);
      drain("nextline");

      do_load(32'hFFFF_0000, 32'h0001_0000, 32'h0);
      step();
      expect_ph(32'h0000_FFFF, 32'h0002_0001);
      drain("wrap");

      zstart = 32'h0020_0000;
      zinc   = 32'h0;
      load   = 1'b1;
      abort  = 1'b1;
      step();
      load   = 1'b0;
      abort  = 1'b0;
      chk("ld_abort_busy", 32'(busy), 32'd1);
      chk("ld_abort_valid", 32'(out_valid), 32'd0);
      step();
      expect_ph(32'h0020_0020, 32'h0020_0020);
      drain("ld_abort");

      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hold", srczplo, 32'h0020_0020);

      do_load(32'h1234_0000, 32'h0001_0000, 32'h0);
      step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      resetl    = 1'b0;
      out_ready = 1'b1;
      load      = 1'b1;
      step();
      load      = 1'b0;
      out_ready = 1'b0;
      resetl    = 1'b1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_lo", srczplo, 32'h0);
      chk("mid_rst_hi", srczphi, 32'h0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule

// File: doc/zed_gen.md
# zed_gen

Source-Z generator for the blitter's Z-buffer path. Holds the interpolated 16.16 Z value for each of the four 16-bit pixels in a phrase and steps it along the inner loop (per phrase) and the outer loop (per line). Presents the integer Z parts as the packed source-Z words that the Z comparator checks against destination Z. This is the producing end of the srcz interface.

## Interface
Parameters:
- NPIX, 4, pixels per phrase; fixed at 4 for 16-bit Z.
- ZW, 32, Z accumulator width, 16.16 fixed point.

Ports:
- clk  in  1  system clock
- resetl  in  1  reset; synchronous, active-low
- load  in  1  start a new blit: capture zstart/zinc/zstep
- zstart  in  32  Z of lane 0, first phrase of first line (16.16)
- zinc  in  32  per-pixel Z increment (16.16, two's complement)
- zstep  in  32  per-line Z increment applied to line-start Z
- nextline  in  1  advance to the next line
- abort  in  1  stop and return to IDLE
- out_ready  in  1  consumer accepts the current phrase
- out_valid  out  1  srczplo/srczphi hold a valid phrase
- srczplo  out  32  {z1[31:16], z0[31:16]}
- srczphi  out  32  {z3[31:16], z2[31:16]}
- busy  out  1  state is not IDLE

## Operation
- Registers: line_z, zinc_r, zstep_r, inc4 = zinc<<2, lanes z0..z3 (32 bits each).
- States: IDLE, RELOAD, RUN.
- IDLE: out_valid=0. On load: line_z<=zstart, zinc_r<=zinc, zstep_r<=zstep, inc4<=zinc<<2, go to RELOAD.
- RELOAD: z_k <= line_z + k*zinc_r for k=0..3. Form k*zinc by shift/add; no multiplier. Go to RUN with out_valid=1.
- RUN: a transfer occurs when out_valid and out_ready are both high. On transfer, every z_k <= z_k + inc4.
- RUN, nextline: line_z <= line_z + zstep_r, out_valid<=0, go to RELOAD. A transfer in the same cycle still completes; its lane increment is discarded.
- nextline in IDLE or RELOAD is ignored.
- abort in any state: go to IDLE, out_valid<=0. Lane and line registers hold their values.
- Priority within a cycle: load > abort > nextline > transfer step.
- load in RUN or RELOAD restarts from the new zstart.
- All arithmetic is modulo 2^32 and wraps silently; no saturation.
- Outputs are the upper 16 bits of each lane, taken directly from registers.

## Timing
- Reset: state IDLE; out_valid=0, busy=0, srczplo=srczphi=0; all internal registers 0.
- Latency is 2 cycles from a load or nextline edge to out_valid=1. The first phrase is stable while out_valid=1 and out_ready=0.
- Throughput is one phrase per cycle in RUN.
- out_valid never drops in RUN except on nextline, abort or reset.
- Outputs change only on the clock edge after a transfer, RELOAD, or reset.
- resetl low mid-blit overrides all inputs that cycle.

## Structure
- Shared blitter package holds:
  - the zed_gen state enum (IDLE/RELOAD/RUN);
  - NPIX;
  - the Z fraction-width constant (16).
- Sub-module zed_lane, instantiated NPIX times. It holds one 32-bit accumulator with a lane index parameter and two operations:
  - reload: base + idx*inc;
  - step: += inc4.
- Top level holds the FSM, line_z, and output packing.

## Test plan
- Reset then idle: out_valid=0, busy=0, srczplo=srczphi=0.
- load, zstart=0x0010_0000, zinc=0x0000_8000, zstep=0 -> out_valid=1 two cycles later, srczplo=0x0010_0010, srczphi=0x0011_0011.
- Same setup, one transfer -> next cycle srczplo=0x0012_0012, srczphi=0x0013_0013. Hold out_ready=0 for 5 cycles -> outputs unchanged.
- nextline with zstep=0x0100_0000 after two transfers -> out_valid=0 for one cycle, then srczplo=0x0110_0110, srczphi=0x0111_0111.
- Wrap: zstart=0xFFFF_0000, zinc=0x0001_0000 -> srczplo=0x0000_FFFF, srczphi=0x0002_0001.
- Simultaneous load+abort goes to RELOAD. Abort alone in RUN gives out_valid=0 and busy=0 next cycle. resetl low mid-RUN -> all outputs 0 next cycle.
